// File: rtl/paddle_ctrl.sv
// Paddle position controller: manual or ball-tracking request, two-speed
// stepping with acceleration, and screen-limit flags. Paddle X is fixed.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no request; paddle holds position, timer and step count clear
//  SLOW  | direction held; one step every STEP_SLOW cycles, counting steps
//  FAST  | ACCEL_STEPS slow steps done; one step every STEP_FAST cycles
module paddle_ctrl #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 80,
  parameter int PADDLE_WIDTH  = 10,
  parameter int X_CENTER      = 20,
  parameter int COORD_W       = 10,
  parameter int STEP_SLOW     = 52000,
  parameter int STEP_FAST     = 26000,
  parameter int ACCEL_STEPS   = 16,
  parameter int AUTO_DEADBAND = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_enable,
  input  logic               i_mode,
  input  logic               i_up,
  input  logic               i_down,
  input  logic [COORD_W-1:0] i_ball_y,
  output logic [COORD_W-1:0] o_left,
  output logic [COORD_W-1:0] o_right,
  output logic [COORD_W-1:0] o_top,
  output logic [COORD_W-1:0] o_bottom,
  output logic [1:0]         o_state,
  output logic               o_at_top,
  output logic               o_at_bottom
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLOW = 2'd1;
  localparam logic [1:0] ST_FAST = 2'd2;

  localparam int TMR_W = (STEP_SLOW > 1) ? $clog2(STEP_SLOW) : 1;
  localparam int CNT_W = $clog2(ACCEL_STEPS + 1);

  // Timer is a down-counter: loaded with period-1, a step is due when it hits 0.
  localparam logic [TMR_W-1:0]   SLOW_LOAD = TMR_W'(STEP_SLOW - 1);
  localparam logic [TMR_W-1:0]   FAST_LOAD = TMR_W'(STEP_FAST - 1);
  localparam logic [CNT_W-1:0]   ACC_LAST  = CNT_W'(ACCEL_STEPS - 1);
  localparam logic [COORD_W-1:0] TOP_INIT  = COORD_W'((SCREEN_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [COORD_W-1:0] BOT_INIT  = COORD_W'((SCREEN_HEIGHT + PADDLE_HEIGHT) / 2);
  localparam logic [COORD_W-1:0] BOT_MAX   = COORD_W'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_W:0]   HALF_H    = (COORD_W+1)'(PADDLE_HEIGHT / 2);
  localparam logic [COORD_W:0]   DEADBAND  = (COORD_W+1)'(AUTO_DEADBAND);

  logic [1:0]         r_state;
  logic               r_dir;      // 0 = up, 1 = down; meaningful only outside IDLE
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_cnt;
  logic [COORD_W-1:0] r_top;
  logic [COORD_W-1:0] r_bottom;

  logic               w_req_up;
  logic               w_req_dn;
  logic [COORD_W:0]   w_centre;
  logic [COORD_W:0]   w_ball;
  logic               w_reverse;
  logic               w_can_move;

  // Direction request from buttons or from ball position (one extra bit, no overflow)
  always_comb begin
    w_centre = {1'b0, r_top} + HALF_H;
    w_ball   = {1'b0, i_ball_y};
    if (i_mode) begin
      w_req_up = (w_ball + DEADBAND) < w_centre;
      w_req_dn = w_ball > (w_centre + DEADBAND);
    end else begin
      w_req_up = i_up & ~i_down;
      w_req_dn = i_down & ~i_up;
    end
    w_reverse  = r_dir ? w_req_up : w_req_dn;
    w_can_move = r_dir ? (r_bottom != BOT_MAX) : (r_top != '0);
  end

  // Sequencer: request tracking, step timing, acceleration and position update
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || !i_enable) begin
      r_state  <= ST_IDLE;
      r_dir    <= 1'b0;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_top    <= TOP_INIT;
      r_bottom <= BOT_INIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          r_cnt   <= '0;
          if (w_req_up || w_req_dn) begin
            r_state <= ST_SLOW;
            r_dir   <= w_req_dn;
            r_timer <= SLOW_LOAD;
          end
        end
        ST_SLOW, ST_FAST: begin
          if (!w_req_up && !w_req_dn) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_cnt   <= '0;
          end else if (w_reverse) begin
            r_state <= ST_SLOW;
            r_dir   <= w_req_dn;
            r_timer <= SLOW_LOAD;
            r_cnt   <= '0;
          end else if (r_timer == '0) begin
            // Limits only freeze position; timing and acceleration keep running
            if (w_can_move) begin
              if (r_dir) begin
                r_top    <= r_top + 1'b1;
                r_bottom <= r_bottom + 1'b1;
              end else begin
                r_top    <= r_top - 1'b1;
                r_bottom <= r_bottom - 1'b1;
              end
            end
            if (r_state == ST_SLOW) begin
              if (r_cnt == ACC_LAST) begin
                r_state <= ST_FAST;
                r_timer <= FAST_LOAD;
                r_cnt   <= '0;
              end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_timer <= SLOW_LOAD;
              end
            end else begin
              r_timer <= FAST_LOAD;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_left      = COORD_W'(X_CENTER - PADDLE_WIDTH / 2);
  assign o_right     = COORD_W'(X_CENTER + PADDLE_WIDTH / 2);
  assign o_top       = r_top;
  assign o_bottom    = r_bottom;
  assign o_state     = r_state;
  assign o_at_top    = (r_top == '0);
  assign o_at_bottom = (r_bottom == BOT_MAX);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with short step periods. A position/run-length model
// predicts every output each cycle; directed phases add literal checkpoints.
module tb_paddle_ctrl;

  localparam int SH  = 480;
  localparam int PH  = 80;
  localparam int S   = 4;
  localparam int F   = 2;
  localparam int A   = 3;
  localparam int DB  = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, up, down;
  logic [9:0] ball;
  logic [9:0] left, right, top, bottom;
  logic [1:0] state;
  logic       at_top, at_bottom;

  int n_checks = 0;
  int n_fail   = 0;

  paddle_ctrl #(
    .STEP_SLOW(S), .STEP_FAST(F), .ACCEL_STEPS(A)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_enable(en), .i_mode(mode),
    .i_up(up), .i_down(down), .i_ball_y(ball),
    .o_left(left), .o_right(right), .o_top(top), .o_bottom(bottom),
    .o_state(state), .o_at_top(at_top), .o_at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: paddle top, the direction currently held (0 none, 1 up, 2 down)
  // and the number of cycles that direction has been held since the run began.
  int m_top   = 0;
  int m_run   = 0;
  int m_n     = 0;
  bit m_valid = 0;

  function automatic int request(input int md, input int u, input int d,
                                 input int b, input int t);
    int c;
    if (md == 0) begin
      if (u == 1 && d == 0) return 1;
      if (d == 1 && u == 0) return 2;
      return 0;
    end
    c = t + PH / 2;
    if (b + DB < c) return 1;
    if (b > c + DB) return 2;
    return 0;
  endfunction

  // Steps land at S, 2S .. A*S cycles into a run, then every F cycles after.
  function automatic bit step_due(input int n);
    if (n <= A * S) return (n % S) == 0;
    return ((n - A * S) % F) == 0;
  endfunction

  always @(posedge clk) begin
    int r;
    if (!rst_n || !en) begin
      m_top = (SH - PH) / 2;
      m_run = 0;
      m_n   = 0;
      if (!rst_n) m_valid = 1;
    end else begin
      r = request(int'(mode), int'(up), int'(down), int'(ball), m_top);
      if (r == 0) begin
        m_run = 0;
        m_n   = 0;
      end else if (r != m_run) begin
        m_run = r;
        m_n   = 0;
      end else begin
        m_n++;
        if (step_due(m_n)) begin
          if (r == 1 && m_top > 0) m_top--;
          else if (r == 2 && m_top + PH < SH - 1) m_top++;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("top",       int'(top),       m_top);
      check("bottom",    int'(bottom),    m_top + PH);
      check("state",     int'(state),     (m_run == 0) ? 0 : ((m_n >= A * S) ? 2 : 1));
      check("at_top",    int'(at_top),    (m_top == 0) ? 1 : 0);
      check("at_bottom", int'(at_bottom), (m_top + PH == SH - 1) ? 1 : 0);
      check("left",      int'(left),      15);
      check("right",     int'(right),     25);
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; up = 1'b0; down = 1'b0; ball = '0;
    ticks(2);
    check("reset_top", int'(top), 200);
    check("reset_bottom", int'(bottom), 280);
    check("reset_state", int'(state), 0);

    // 1: manual up, slow then fast
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    ticks(1);  check("t1_enter_state", int'(state), 1);
               check("t1_enter_top", int'(top), 200);
    ticks(3);  check("t1_pre_step", int'(top), 200);
    ticks(1);  check("t1_step1", int'(top), 199);
    ticks(4);  check("t1_step2", int'(top), 198);
    ticks(4);  check("t1_step3", int'(top), 197);
               check("t1_fast", int'(state), 2);
    ticks(2);  check("t1_step4", int'(top), 196);
    ticks(2);  check("t1_step5", int'(top), 195);

    // 2: reversal drops back to slow, then release
    up = 1'b0; down = 1'b1;
    ticks(1);  check("t2_rev_state", int'(state), 1);
    ticks(3);  check("t2_rev_hold", int'(top), 195);
    ticks(1);  check("t2_rev_step", int'(top), 196);
    down = 1'b0;
    ticks(1);  check("t2_idle", int'(state), 0);
    ticks(3);  check("t2_hold", int'(top), 196);

    // 3: limits
    up = 1'b1;
    ticks(600); check("t3_top0", int'(top), 0);
                check("t3_at_top", int'(at_top), 1);
    up = 1'b0; down = 1'b1;
    ticks(1000); check("t3_bot479", int'(bottom), 479);
                 check("t3_at_bottom", int'(at_bottom), 1);

    // 4: both buttons, then enable drop mid-move
    up = 1'b1;
    ticks(5);  check("t4_both_state", int'(state), 0);
               check("t4_both_top", int'(top), 399);
    down = 1'b0;
    ticks(10); check("t4_moving", int'(top), 397);
    en = 1'b0;
    ticks(1);  check("t4_dis_top", int'(top), 200);
               check("t4_dis_bottom", int'(bottom), 280);
               check("t4_dis_state", int'(state), 0);

    // 5: auto tracking
    en = 1'b1; up = 1'b0; mode = 1'b1; ball = 10'd244;
    ticks(10);  check("t5_dead_top", int'(top), 200);
                check("t5_dead_state", int'(state), 0);
    ball = 10'd300;
    ticks(300); check("t5_down_top", int'(top), 256);
                check("t5_down_state", int'(state), 0);
    ball = 10'd100;
    ticks(500); check("t5_up_top", int'(top), 64);

    // 6: reset during fast, next run restarts slow
    mode = 1'b0; up = 1'b1;
    ticks(14); check("t6_fast", int'(state), 2);
    rst_n = 1'b0;
    ticks(1);  check("t6_rst_top", int'(top), 200);
               check("t6_rst_state", int'(state), 0);
    rst_n = 1'b1;
    ticks(4);  check("t6_slow_hold", int'(top), 200);
    ticks(1);  check("t6_slow_step", int'(top), 199);

    // Random segments: every cycle is checked against the model
    for (int seg = 0; seg < 250; seg++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      en    = ($urandom_range(0, 25) != 0);
      if ($urandom_range(0, 4) == 0) mode = ~mode;
      case ($urandom_range(0, 5))
        0:       begin up = 1'b0; down = 1'b0; end
        1:       begin up = 1'b1; down = 1'b1; end
        2, 3:    begin up = 1'b1; down = 1'b0; end
        default: begin up = 1'b0; down = 1'b1; end
      endcase
      ball = 10'($urandom_range(0, 479));
      ticks(1);
      rst_n = 1'b1;
      ticks($urandom_range(1, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised paddle position controller for the PONG datapath. Supersedes the fixed-speed paddle with three additions: selectable manual (button) or auto (ball-tracking) mode, two-speed acceleration while a direction is held, and explicit limit flags. It drives the paddle bounding box into the renderer and collision logic. Paddle X is fixed; Y moves one pixel per step.

Parameters:
SCREEN_HEIGHT, 480, visible lines; Y range is 0..SCREEN_HEIGHT-1
PADDLE_HEIGHT, 80, paddle height in pixels (bottom = top + PADDLE_HEIGHT)
PADDLE_WIDTH, 10, paddle width in pixels (even)
X_CENTER, 20, paddle column centre
COORD_W, 10, coordinate width
STEP_SLOW, 52000, clock cycles per step in SLOW (>=2)
STEP_FAST, 26000, clock cycles per step in FAST (>=2, <=STEP_SLOW)
ACCEL_STEPS, 16, SLOW steps taken before switching to FAST (>=1)
AUTO_DEADBAND, 4, auto-mode dead zone around paddle centre, in pixels

Ports:
i_Clk  in  1  clock
i_Rst_n  in  1  synchronous reset, active-low
i_enable  in  1  1 = play; 0 = recentre and hold
i_mode  in  1  0 = manual (i_up/i_down), 1 = auto (track i_ball_y)
i_up  in  1  move-up button, level
i_down  in  1  move-down button, level
i_ball_y  in  COORD_W  ball centre Y, used in auto mode only
o_left  out  COORD_W  X_CENTER - PADDLE_WIDTH/2, constant
o_right  out  COORD_W  X_CENTER + PADDLE_WIDTH/2, constant
o_top  out  COORD_W  paddle top Y, registered
o_bottom  out  COORD_W  o_top + PADDLE_HEIGHT, registered
o_state  out  2  FSM state: 0 IDLE, 1 SLOW, 2 FAST
o_at_top  out  1  combinational, o_top == 0
o_at_bottom  out  1  combinational, o_bottom == SCREEN_HEIGHT-1

Behaviour:
- Reset (i_Rst_n=0 at a clock edge) and i_enable=0 have identical effect, reset takes priority: o_top=(SCREEN_HEIGHT-PADDLE_HEIGHT)/2 (200), o_bottom=(SCREEN_HEIGHT+PADDLE_HEIGHT)/2 (280), state IDLE, timer=0, step count=0, latched direction=none. Both apply mid-move with no residual step.
- Request (combinational), manual: UP = i_up & ~i_down; DOWN = i_down & ~i_up; both or neither = NONE.
- Request, auto: centre = o_top + PADDLE_HEIGHT/2. UP if i_ball_y + AUTO_DEADBAND < centre; DOWN if i_ball_y > centre + AUTO_DEADBAND; else NONE. Compare at COORD_W+1 bits so there is no overflow.
- IDLE: request != NONE -> SLOW, latch dir, timer=0, step count=0. There is no position change on entry.
- SLOW/FAST, request == NONE -> IDLE, timer=0, step count=0.
- SLOW/FAST, request opposite to latched dir -> SLOW with the new dir latched, timer=0, step count=0. This includes FAST->SLOW on reversal.
- SLOW/FAST, request == dir: if timer == PERIOD-1 (PERIOD = STEP_SLOW or STEP_FAST), then timer=0 and a step is taken; otherwise timer+1.
- Step: UP with o_top != 0 does o_top-1 and o_bottom-1. DOWN with o_bottom != SCREEN_HEIGHT-1 does +1 on both. At a limit the position holds, but timing and acceleration still advance.
- Acceleration: each SLOW step increments the step count. The step where the count reaches ACCEL_STEPS moves the state to FAST, with timer=0. FAST persists until NONE or reversal.
- Latency: the first pixel move occurs exactly STEP_SLOW cycles after the edge that enters SLOW. FAST steps occur every STEP_FAST cycles.
- A mode switch mid-move is treated only as a request change; the rules above apply.
- o_bottom - o_top == PADDLE_HEIGHT always holds, and o_top never underflows.

Test Plan:
1. Params STEP_SLOW=4, STEP_FAST=2, ACCEL_STEPS=3. Reset, then i_enable=1, i_mode=0, hold i_up -> o_top 200 steps to 199, 198, 197 at 4-cycle intervals, then o_state=2 and 196, 195 at 2-cycle intervals.
2. In FAST moving up, switch to i_down only -> o_state=1 the next cycle, and the first downward step comes 4 cycles later. Then release both -> o_state=0 and o_top holds.
3. Hold i_up from o_top=2 long enough -> o_top reaches 0, o_at_top=1, o_top stays 0 and never wraps to 1023. Mirror test with i_down: o_bottom stops at 479 and o_at_bottom=1.
4. i_up=i_down=1 -> state IDLE, no movement. Drop i_enable mid-move -> next cycle o_top=200, o_bottom=280, o_state=0.
5. Auto mode, o_top=200 (centre 240), AUTO_DEADBAND=4: i_ball_y=244 -> no move; i_ball_y=300 -> moves down until centre >= 296, then stops; i_ball_y=100 -> moves up.
6. Drive i_Rst_n=0 for one edge during FAST, with i_enable=1 -> o_top=200, o_state=0, and the next first step takes a full STEP_SLOW interval.
